// File: rtl/dmem_arb_defs.sv
// Shared definitions for the data-memory arbiter: port identifiers and the
// byte-enable encoding that marks a read access.
package dmem_arb_defs;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_EXT = 1'b1
  } port_e;

  // All-zero byte enables mean the access is a read.
  localparam int unsigned DMEM_BE_READ = 0;

endpackage

// File: rtl/rr_pick2.sv
// Two-way grant picker: a locked owner keeps the port until it stops asking
// or hits its burst limit while the other side waits; otherwise round-robin.
module rr_pick2
  import dmem_arb_defs::*;
(
  input  logic [1:0] i_req,
  input  port_e      i_last_grant,
  input  port_e      i_owner,
  input  logic       i_owner_valid,
  input  logic       i_burst_at_limit,
  output logic [1:0] o_gnt
);

  // Owner continuation, then tie-break against the last winner, then sole requester.
  always_comb begin
    o_gnt = '0;
    if (i_owner_valid && i_req[i_owner] &&
        (!i_burst_at_limit || !i_req[~i_owner])) begin
      o_gnt[i_owner] = 1'b1;
    end else if (&i_req) begin
      o_gnt[~i_last_grant] = 1'b1;
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one BRAM port between the CPU path (port 0) and an external master
// (port 1). Grant is combinational; read data returns one cycle later, tagged
// with the port that issued the read.
module dmem_arbiter
  import dmem_arb_defs::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                    sysclk,
  input  logic                    rst,
  input  logic                    p0_req,
  input  logic                    p0_lock,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_byte_w_en,
  output logic                    p0_gnt,
  output logic                    p0_rvalid,
  output logic [DATA_WIDTH-1:0]   p0_rdata,
  input  logic                    p1_req,
  input  logic                    p1_lock,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_byte_w_en,
  output logic                    p1_gnt,
  output logic                    p1_rvalid,
  output logic [DATA_WIDTH-1:0]   p1_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_byte_w_en,
  output logic                    mem_r_en,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST - 1);
  localparam logic [BE_W-1:0]  BE_READ   = BE_W'(DMEM_BE_READ);

  port_e            r_last_grant;
  logic             r_owner_valid;
  port_e            r_owner;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_rvalid;
  port_e            r_rport;

  logic [1:0]            w_pick_gnt;
  logic [1:0]            w_gnt;
  logic                  w_granted;
  port_e                 w_g;
  logic                  w_lock_g;
  logic                  w_burst_at_limit;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [BE_W-1:0]       w_mem_be;
  logic                  w_mem_r_en;

  assign w_burst_at_limit = (r_burst_cnt >= CNT_LIMIT);

  rr_pick2 u_pick (
    .i_req            ({p1_req, p0_req}),
    .i_last_grant     (r_last_grant),
    .i_owner          (r_owner),
    .i_owner_valid    (r_owner_valid),
    .i_burst_at_limit (w_burst_at_limit),
    .o_gnt            (w_pick_gnt)
  );

  // Nothing is granted while reset is held.
  assign w_gnt     = rst ? w_pick_gnt : 2'b00;
  assign w_granted = |w_gnt;
  assign w_g       = w_gnt[1] ? PORT_EXT : PORT_CPU;
  assign w_lock_g  = w_gnt[1] ? p1_lock : p0_lock;

  // Route the granted port's request onto the BRAM side; idle bus is all zero.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_be    = '0;
    if (w_gnt[0]) begin
      w_mem_addr  = p0_addr;
      w_mem_wdata = p0_wdata;
      w_mem_be    = p0_byte_w_en;
    end else if (w_gnt[1]) begin
      w_mem_addr  = p1_addr;
      w_mem_wdata = p1_wdata;
      w_mem_be    = p1_byte_w_en;
    end
  end

  assign w_mem_r_en    = w_granted && (w_mem_be == BE_READ);
  assign mem_addr      = w_mem_addr;
  assign mem_wdata     = w_mem_wdata;
  assign mem_byte_w_en = w_mem_be;
  assign mem_r_en      = w_mem_r_en;

  assign p0_gnt = w_gnt[0];
  assign p1_gnt = w_gnt[1];

  // Track round-robin history, burst ownership and the pending read return.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      r_last_grant  <= PORT_EXT;
      r_owner_valid <= 1'b0;
      r_owner       <= PORT_CPU;
      r_burst_cnt   <= '0;
      r_rvalid      <= 1'b0;
      r_rport       <= PORT_CPU;
    end else begin
      r_rvalid <= w_mem_r_en;
      r_rport  <= w_g;
      if (w_granted) begin
        r_last_grant <= w_g;
        if (w_lock_g) begin
          if (r_owner_valid && (r_owner == w_g)) begin
            if (r_burst_cnt != CNT_LIMIT) begin
              r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end
          end else begin
            // New owner, including the port that won a forced rotation.
            r_owner       <= w_g;
            r_owner_valid <= 1'b1;
            r_burst_cnt   <= '0;
          end
        end else begin
          r_owner_valid <= 1'b0;
          r_burst_cnt   <= '0;
        end
      end else begin
        r_owner_valid <= 1'b0;
        r_burst_cnt   <= '0;
      end
    end
  end

  assign p0_rvalid = rst && r_rvalid && (r_rport == PORT_CPU);
  assign p1_rvalid = rst && r_rvalid && (r_rport == PORT_EXT);
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of per-cycle stimulus with expected grants,
// a behavioural BRAM with registered read, and a read-return scoreboard.
module tb_dmem_arbiter;

  logic        sysclk;
  logic        rst;
  logic        p0_req, p0_lock, p1_req, p1_lock;
  logic [11:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [3:0]  p0_byte_w_en, p1_byte_w_en;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_w_en;
  logic        mem_r_en;
  logic [31:0] mem_rdata;

  dmem_arbiter #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (32),
    .MAX_BURST  (8)
  ) dut (
    .sysclk        (sysclk),
    .rst           (rst),
    .p0_req        (p0_req),
    .p0_lock       (p0_lock),
    .p0_addr       (p0_addr),
    .p0_wdata      (p0_wdata),
    .p0_byte_w_en  (p0_byte_w_en),
    .p0_gnt        (p0_gnt),
    .p0_rvalid     (p0_rvalid),
    .p0_rdata      (p0_rdata),
    .p1_req        (p1_req),
    .p1_lock       (p1_lock),
    .p1_addr       (p1_addr),
    .p1_wdata      (p1_wdata),
    .p1_byte_w_en  (p1_byte_w_en),
    .p1_gnt        (p1_gnt),
    .p1_rvalid     (p1_rvalid),
    .p1_rdata      (p1_rdata),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_byte_w_en (mem_byte_w_en),
    .mem_r_en      (mem_r_en),
    .mem_rdata     (mem_rdata)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Behavioural BRAM: word i preloaded with 0xC0DE0iii, byte writes, registered read.
  logic [31:0] mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {16'hC0DE, 4'h0, 12'(i)};
    mem_rdata = '0;
    forever begin
      @(posedge sysclk);
      if (mem_r_en) mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_byte_w_en[b]) mem[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  typedef struct {
    logic        rst;
    logic        r0, l0;
    logic [11:0] a0;
    logic [3:0]  b0;
    logic [31:0] d0;
    logic        r1, l1;
    logic [11:0] a1;
    logic [3:0]  b1;
    logic [31:0] d1;
    logic [1:0]  eg;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } rd_t;

  vec_t tbl[$];
  rd_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   wrote20 = 1'b0;

  function automatic vec_t mk(input logic rs,
                              input logic r0, input logic l0, input logic [11:0] a0,
                              input logic [3:0] b0, input logic [31:0] d0,
                              input logic r1, input logic l1, input logic [11:0] a1,
                              input logic [3:0] b1, input logic [31:0] d1,
                              input logic [1:0] eg);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.l0 = l0; v.a0 = a0; v.b0 = b0; v.d0 = d0;
    v.r1 = r1; v.l1 = l1; v.a1 = a1; v.b1 = b1; v.d1 = d1; v.eg = eg;
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [11:0] a);
    if (a == 12'h020 && wrote20) return 32'hC0DE_BEEF;
    return {16'hC0DE, 4'h0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample mid-low-phase, check, then record reads.
  task automatic step(input vec_t v);
    rd_t         e;
    logic        ev0, ev1;
    logic [31:0] ed0, ed1, ea, ew;
    logic [3:0]  eb;
    logic        er;
    @(negedge sysclk);
    rst = v.rst;
    p0_req = v.r0; p0_lock = v.l0; p0_addr = v.a0; p0_byte_w_en = v.b0; p0_wdata = v.d0;
    p1_req = v.r1; p1_lock = v.l1; p1_addr = v.a1; p1_byte_w_en = v.b1; p1_wdata = v.d1;
    #2;
    if (!v.rst) sb.delete();
    ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) begin ev1 = 1'b1; ed1 = e.data; end
      else begin ev0 = 1'b1; ed0 = e.data; end
    end
    chk("p0_rvalid", 32'(p0_rvalid), 32'(ev0));
    chk("p1_rvalid", 32'(p1_rvalid), 32'(ev1));
    chk("p0_rdata", p0_rdata, ed0);
    chk("p1_rdata", p1_rdata, ed1);
    ea = '0; ew = '0; eb = '0; er = 1'b0;
    if (v.eg[0]) begin
      ea = 32'(v.a0); ew = v.d0; eb = v.b0; er = (v.b0 == 4'h0);
    end else if (v.eg[1]) begin
      ea = 32'(v.a1); ew = v.d1; eb = v.b1; er = (v.b1 == 4'h0);
    end
    chk("gnt", 32'({p1_gnt, p0_gnt}), 32'(v.eg));
    chk("mem_addr", 32'(mem_addr), ea);
    chk("mem_wdata", mem_wdata, ew);
    chk("mem_byte_w_en", 32'(mem_byte_w_en), 32'(eb));
    chk("mem_r_en", 32'(mem_r_en), 32'(er));
    if (v.eg[0] && v.b0 == 4'h0) begin e.port = 1'b0; e.data = exp_rd(v.a0); sb.push_back(e); end
    if (v.eg[1] && v.b1 == 4'h0) begin e.port = 1'b1; e.data = exp_rd(v.a1); sb.push_back(e); end
    if (v.eg[1] && v.b1 != 4'h0 && v.a1 == 12'h020) wrote20 = 1'b1;
  endtask

  vec_t idle;
  vec_t rst_idle;

  initial begin
    rst = 1'b0;
    p0_req = 0; p0_lock = 0; p0_addr = '0; p0_byte_w_en = '0; p0_wdata = '0;
    p1_req = 0; p1_lock = 0; p1_addr = '0; p1_byte_w_en = '0; p1_wdata = '0;
    idle     = mk(1, 0,0,12'h0,4'h0,32'h0, 0,0,12'h0,4'h0,32'h0, 2'b00);
    rst_idle = mk(0, 0,0,12'h0,4'h0,32'h0, 0,0,12'h0,4'h0,32'h0, 2'b00);

    // Reset: requests present but nothing granted.
    tbl.push_back(mk(0, 1,0,12'h010,4'h0,32'h0, 1,1,12'h020,4'h0,32'h0, 2'b00));
    tbl.push_back(rst_idle);
    // Sole p0 read of 0x010, data returns next cycle.
    tbl.push_back(mk(1, 1,0,12'h010,4'h0,32'h0, 0,0,12'h0,4'h0,32'h0, 2'b01));
    tbl.push_back(idle);
    // Fresh reset, then both requesting: strict alternation starting at port 0.
    tbl.push_back(rst_idle);
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(1, 1,0,12'h030,4'h0,32'h0, 1,0,12'h041,4'h0,32'h0,
                       (k % 2 == 0) ? 2'b01 : 2'b10));
    tbl.push_back(idle);
    // Partial write from port 1, then read back from port 0.
    tbl.push_back(mk(1, 0,0,12'h0,4'h0,32'h0, 1,0,12'h020,4'b0011,32'hDEAD_BEEF, 2'b10));
    tbl.push_back(mk(1, 1,0,12'h020,4'h0,32'h0, 0,0,12'h0,4'h0,32'h0, 2'b01));
    tbl.push_back(idle);
    // Idle bus with junk on the non-requesting inputs.
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 0,1,12'hFFF,4'hF,32'hFFFF_FFFF, 0,1,12'hABC,4'hF,32'h1234_5678, 2'b00));

    foreach (tbl[i]) step(tbl[i]);

    // Port 1 locked burst; port 0 joins at cycle 3 and is served every 9th cycle.
    for (int k = 0; k < 20; k++)
      step(mk(1, (k >= 3),0,12'h050,4'h0,32'h0, 1,1,12'h060,4'h0,32'h0,
              (k == 8 || k == 17) ? 2'b01 : 2'b10));
    step(idle);

    // Reset right after a granted p0 read: no data comes back, tie goes to port 0.
    step(rst_idle);
    step(mk(1, 1,0,12'h080,4'h0,32'h0, 1,1,12'h090,4'h0,32'h0, 2'b01));
    step(mk(0, 1,0,12'h080,4'h0,32'h0, 1,1,12'h090,4'h0,32'h0, 2'b00));
    step(mk(0, 1,0,12'h080,4'h0,32'h0, 1,1,12'h090,4'h0,32'h0, 2'b00));
    step(mk(1, 1,0,12'h080,4'h0,32'h0, 1,0,12'h090,4'h0,32'h0, 2'b01));
    step(idle);

    // Reset while port 1 owns a lock: ownership must not survive.
    step(mk(1, 0,0,12'h0,4'h0,32'h0, 1,1,12'h0A0,4'h0,32'h0, 2'b10));
    step(mk(0, 1,0,12'h0B0,4'h0,32'h0, 1,1,12'h0A0,4'h0,32'h0, 2'b00));
    step(mk(1, 1,0,12'h0B0,4'h0,32'h0, 1,1,12'h0A0,4'h0,32'h0, 2'b01));
    step(idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
